// File: rtl/fibre_tx_encoder.sv
// Manchester line encoder: bytes in over valid/ready, 10-bit typed symbols out
// on one serial pin, with idle/sync symbols filling gaps and forced periodically.
module fibre_tx_encoder #(
    parameter int         CLKS_PER_HALFBIT = 4,
    parameter logic [7:0] SYNC_WORD        = 8'hA5,
    parameter int         SYNC_INTERVAL    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_in,
    input  logic       d_in_valid,
    output logic       d_in_ready,
    output logic       tx_out,
    output logic       symbol_start,
    output logic       sending_data
);

    localparam int HW = (CLKS_PER_HALFBIT > 1) ? $clog2(CLKS_PER_HALFBIT) : 1;
    localparam int CW = (SYNC_INTERVAL > 0) ? $clog2(SYNC_INTERVAL + 1) : 1;
    localparam logic [HW-1:0] HB_LAST = HW'(CLKS_PER_HALFBIT - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SYNC_INTERVAL);

    logic          running;
    logic [HW-1:0] hb_cnt;
    logic          phase;
    logic [3:0]    bit_idx;
    logic [9:0]    sym;
    logic [7:0]    hold;
    logic          hold_full;
    logic [CW-1:0] data_cnt;

    logic          half_end;
    logic          boundary;
    logic          take_data;
    logic          accept;
    logic          hold_nxt;
    logic [9:0]    new_sym;
    logic [HW-1:0] nxt_hb;
    logic          nxt_phase;
    logic [3:0]    nxt_bit;

    // sym[0] is sent first: hdr[1], hdr[0], then payload LSB first
    always_comb begin
        half_end  = (hb_cnt == HB_LAST);
        boundary  = !running || (half_end && phase && (bit_idx == 4'd9));
        take_data = hold_full &&
                    ((SYNC_INTERVAL == 0) || (data_cnt < CNT_MAX));
        accept    = d_in_valid && d_in_ready;
        hold_nxt  = (boundary && take_data) ? 1'b0 :
                    (accept ? 1'b1 : hold_full);
        new_sym   = take_data ? {hold, 2'b01} : {SYNC_WORD, 2'b10};
    end

    always_comb begin
        nxt_hb    = hb_cnt + 1'b1;
        nxt_phase = phase;
        nxt_bit   = bit_idx;
        if (half_end) begin
            nxt_hb    = '0;
            nxt_phase = !phase;
            if (phase) begin
                nxt_bit = bit_idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running      <= 1'b0;
            hb_cnt       <= '0;
            phase        <= 1'b0;
            bit_idx      <= 4'd0;
            sym          <= '0;
            hold         <= '0;
            hold_full    <= 1'b0;
            data_cnt     <= '0;
            d_in_ready   <= 1'b0;
            tx_out       <= 1'b0;
            symbol_start <= 1'b0;
            sending_data <= 1'b0;
        end else begin
            running    <= 1'b1;
            hold_full  <= hold_nxt;
            d_in_ready <= !hold_nxt;
            if (accept) begin
                hold <= d_in;
            end
            if (boundary) begin
                sym          <= new_sym;
                tx_out       <= new_sym[0];
                hb_cnt       <= '0;
                phase        <= 1'b0;
                bit_idx      <= 4'd0;
                symbol_start <= 1'b1;
                sending_data <= take_data;
                if (!take_data) begin
                    data_cnt <= '0;
                end else if (SYNC_INTERVAL != 0) begin
                    data_cnt <= data_cnt + 1'b1;
                end
            end else begin
                hb_cnt       <= nxt_hb;
                phase        <= nxt_phase;
                bit_idx      <= nxt_bit;
                tx_out       <= sym[nxt_bit] ^ nxt_phase;
                symbol_start <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fibre_tx_encoder.sv
// Bench for fibre_tx_encoder: two instances (forced sync every 16 / never),
// symbol-level reference model feeding a scoreboard checked by a serial decoder.
module tb_fibre_tx_encoder;

    localparam int HB  = 4;
    localparam int SYM = 20 * HB;

    typedef struct {
        logic [7:0] b;
        int         phase;
    } stim_t;

    typedef struct {
        bit         is_data;
        logic [7:0] b;
    } sym_t;

    logic  clk = 1'b0;
    logic  rst;
    int    total = 0;
    int    bad   = 0;
    stim_t src_q [2][$];

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input int g,
                         input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h want=%0h t=%0t",
                     name, g, got, want, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam int SI = (g == 0) ? 16 : 0;

        logic [7:0] din;
        logic       vld;
        logic       rdy_o;
        logic       tx;
        logic       ss;
        logic       sd;
        sym_t       exp_q[$];

        fibre_tx_encoder #(
            .CLKS_PER_HALFBIT(HB),
            .SYNC_WORD(8'hA5),
            .SYNC_INTERVAL(SI)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .d_in(din),
            .d_in_valid(vld),
            .d_in_ready(rdy_o),
            .tx_out(tx),
            .symbol_start(ss),
            .sending_data(sd)
        );

        // Driver plus reference model: symbols start every SYM clocks after
        // reset; at each start a held byte goes out unless SI data symbols
        // have already run back to back.
        initial begin
            int    cyc;
            int    cnt;
            bit    hf;
            bit    rdy;
            bit    seen;
            bit    offering;
            bit    offer;
            logic [7:0] hb;
            stim_t cur;
            sym_t  s;
            cyc = 0; cnt = 0; hf = 0; rdy = 0; seen = 0; offering = 0;
            hb = '0;
            vld = 1'b0;
            din = '0;
            forever begin
                @(negedge clk);
                #1;
                if (seen) check("ready", g, 32'(rdy_o), 32'(rdy));
                offer = 0;
                if (!rst && src_q[g].size() > 0) begin
                    cur = src_q[g][0];
                    offer = offering || cur.phase < 0 ||
                            (cyc % SYM) == cur.phase;
                end
                vld = offer;
                din = offer ? cur.b : 8'($urandom);
                if (rst) begin
                    seen = 1; hf = 0; rdy = 0; cnt = 0; cyc = 0;
                    offering = 0;
                    exp_q.delete();
                end else begin
                    if ((cyc % SYM) == 0) begin
                        if (hf && (SI == 0 || cnt < SI)) begin
                            s.is_data = 1; s.b = hb;
                            hf = 0;
                            cnt++;
                        end else begin
                            s.is_data = 0; s.b = 8'hA5;
                            cnt = 0;
                        end
                        exp_q.push_back(s);
                    end
                    if (offer && rdy) begin
                        hb = cur.b;
                        hf = 1;
                        offering = 0;
                        void'(src_q[g].pop_front());
                    end else if (offer) begin
                        offering = 1;
                    end
                    rdy = !hf;
                    cyc++;
                end
            end
        end

        // Monitor: frame on symbol_start, decode Manchester, score symbols.
        initial begin
            logic       smp [SYM];
            int         n;
            bit         col;
            bit         armed;
            bit         stray;
            bit         sd_bad;
            bit         man_ok;
            logic       sd0;
            logic [9:0] bits;
            sym_t       e;
            n = 0; col = 0; armed = 0; stray = 0; sd_bad = 0; sd0 = 0;
            forever begin
                @(posedge clk);
                #2;
                if (rst) begin
                    armed = 1;
                    col = 0;
                    check("reset_out", g, 32'({tx, rdy_o, ss, sd}), 32'd0);
                end else if (armed) begin
                    if (!col) begin
                        check("frame_start", g, 32'(ss), 32'd1);
                        col = 1; n = 0; stray = 0; sd_bad = 0; sd0 = sd;
                    end else if (ss !== 1'b0) begin
                        stray = 1;
                    end
                    if (sd !== sd0) sd_bad = 1;
                    smp[n] = tx;
                    n++;
                    if (n == SYM) begin
                        col = 0;
                        man_ok = 1;
                        for (int b = 0; b < 10; b++) begin
                            bits[b] = smp[b*2*HB];
                            for (int k = 0; k < HB; k++) begin
                                if (smp[b*2*HB+k] !== bits[b]) man_ok = 0;
                                if (smp[b*2*HB+HB+k] !== ~bits[b]) man_ok = 0;
                            end
                        end
                        check("manchester", g, 32'(man_ok), 32'd1);
                        check("no_stray_start", g, 32'(stray), 32'd0);
                        check("sd_stable", g, 32'(sd_bad), 32'd0);
                        check("exp_avail", g, 32'(exp_q.size() > 0), 32'd1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("hdr", g, 32'({bits[0], bits[1]}),
                                  e.is_data ? 32'd2 : 32'd1);
                            check("payload", g, 32'(bits[9:2]), 32'(e.b));
                            check("sending_data", g, 32'(sd0),
                                  32'(e.is_data));
                        end
                    end
                end
            end
        end
    end

    task automatic push_both(input logic [7:0] b, input int phase);
        stim_t s;
        s.b = b;
        s.phase = phase;
        src_q[0].push_back(s);
        src_q[1].push_back(s);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((src_q[0].size() > 0 || src_q[1].size() > 0) && k < 10000) begin
            @(negedge clk);
            k++;
        end
        check(name, 0, 32'(src_q[0].size() + src_q[1].size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * SYM + 10) @(negedge clk);

        push_both(8'h3C, 30);
        wait_drain("drain_single");
        repeat (2 * SYM + 40) @(negedge clk);

        for (int i = 0; i < 20; i++) push_both(8'(i), -1);
        wait_drain("drain_stream20");
        repeat (2 * SYM + 40) @(negedge clk);

        push_both(8'h5A, 0);
        wait_drain("drain_boundary");
        repeat (2 * SYM + 40) @(negedge clk);

        push_both(8'hC3, -1);
        push_both(8'hEE, -1);
        wait_drain("drain_pre_reset");
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * SYM + 20) @(negedge clk);

        for (int i = 0; i < 40; i++) push_both(8'($urandom), -1);
        wait_drain("drain_stream40");
        repeat (2 * SYM) @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            push_both(8'($urandom),
                      ($urandom_range(0, 3) == 0) ? -1
                                                  : int'($urandom_range(0, SYM - 1)));
        end
        wait_drain("drain_random");
        repeat (2 * SYM + 10) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
